// File: rtl/deck_dealer.sv
// Deck owner and N-card dealer: keeps the availability mask and its popcount,
// drives the single-card draw engine. Returns to the deck exist only with DECK_RET_EN.
module deck_dealer #(
    parameter int DECK_SIZE = 106,
    parameter int IDX_W     = 7,
    parameter int NUM_W     = 4,
    parameter int MAX_DEAL  = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interboard_rst,
    input  logic                 deal_req,
    input  logic [NUM_W-1:0]     deal_num,
    input  logic                 draw_ready,
    input  logic                 draw_done,
    input  logic [IDX_W-1:0]     drawn_idx,
    input  logic                 ret_valid,
    input  logic [IDX_W-1:0]     ret_idx,
    output logic                 draw_one,
    output logic [DECK_SIZE-1:0] available_card,
    output logic [IDX_W-1:0]     remain_cnt,
    output logic                 card_valid,
    output logic [IDX_W-1:0]     card_idx,
    output logic                 busy,
    output logic                 deal_done,
    output logic                 deal_short,
    output logic                 ret_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_e;

    state_e               state_q, state_d;
    logic [NUM_W-1:0]     left_q, left_d;
    logic [DECK_SIZE-1:0] avail_q, avail_d;
    logic [IDX_W-1:0]     remain_q, remain_d;
    logic [IDX_W-1:0]     card_idx_q, card_idx_d;
    logic                 card_valid_q, card_valid_d;
    logic                 draw_one_q, draw_one_d;
    logic                 deal_short_q, deal_short_d;
    logic                 ret_err_q, ret_err_d;
    logic                 clr_card, set_card, draw_ok;

    wire reset_any = rst | interboard_rst;

`ifndef DECK_RET_EN
    logic ret_unused;
    assign ret_unused = ^{ret_valid, ret_idx};
`endif

    always_comb begin
        state_d      = state_q;
        left_d       = left_q;
        avail_d      = avail_q;
        card_idx_d   = card_idx_q;
        card_valid_d = 1'b0;
        draw_one_d   = 1'b0;
        deal_short_d = deal_short_q;
        ret_err_d    = 1'b0;
        clr_card     = 1'b0;
        set_card     = 1'b0;
        // An out-of-range or already-dealt index is a failed draw and is retried
        draw_ok      = (drawn_idx < IDX_W'(DECK_SIZE)) && avail_q[drawn_idx];

        unique case (state_q)
            IDLE: begin
                if (deal_req) begin
                    deal_short_d = 1'b0;
                    if (deal_num != '0) begin
                        left_d  = (deal_num > NUM_W'(MAX_DEAL)) ? NUM_W'(MAX_DEAL) : deal_num;
                        state_d = REQ;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            REQ: begin
                if (remain_q == '0) begin
                    deal_short_d = 1'b1;
                    state_d      = FIN;
                end else if (draw_ready) begin
                    draw_one_d = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (draw_done) begin
                    if (draw_ok) begin
                        avail_d[drawn_idx] = 1'b0;
                        clr_card           = 1'b1;
                        card_valid_d       = 1'b1;
                        card_idx_d         = drawn_idx;
                        left_d             = left_q - 1'b1;
                        state_d            = (left_q == NUM_W'(1)) ? FIN : REQ;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DECK_RET_EN
        // A legal return can never target the bit being cleared by a draw
        if (ret_valid) begin
            if ((ret_idx < IDX_W'(DECK_SIZE)) && !avail_q[ret_idx]) begin
                avail_d[ret_idx] = 1'b1;
                set_card         = 1'b1;
            end else begin
                ret_err_d = 1'b1;
            end
        end
`endif

        remain_d = remain_q - IDX_W'(clr_card) + IDX_W'(set_card);
    end

    always_ff @(posedge clk) begin
        if (reset_any) begin
            state_q      <= IDLE;
            left_q       <= '0;
            avail_q      <= '1;
            remain_q     <= IDX_W'(DECK_SIZE);
            card_idx_q   <= '0;
            card_valid_q <= 1'b0;
            draw_one_q   <= 1'b0;
            deal_short_q <= 1'b0;
            ret_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            left_q       <= left_d;
            avail_q      <= avail_d;
            remain_q     <= remain_d;
            card_idx_q   <= card_idx_d;
            card_valid_q <= card_valid_d;
            draw_one_q   <= draw_one_d;
            deal_short_q <= deal_short_d;
            ret_err_q    <= ret_err_d;
        end
    end

    assign draw_one       = draw_one_q;
    assign available_card = avail_q;
    assign remain_cnt     = remain_q;
    assign card_valid     = card_valid_q;
    assign card_idx       = card_idx_q;
    assign busy           = (state_q != IDLE);
    assign deal_done      = (state_q == FIN);
    assign deal_short     = deal_short_q;
    assign ret_err        = ret_err_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer; the bench itself plays the draw engine.
module tb_deck_dealer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         interboard_rst = 1'b0;
    logic         deal_req = 1'b0;
    logic [3:0]   deal_num = '0;
    logic         draw_ready = 1'b1;
    logic         draw_done = 1'b0;
    logic [6:0]   drawn_idx = '0;
    logic         ret_valid = 1'b0;
    logic [6:0]   ret_idx = '0;
    logic         draw_one;
    logic [105:0] available_card;
    logic [6:0]   remain_cnt;
    logic         card_valid;
    logic [6:0]   card_idx;
    logic         busy;
    logic         deal_done;
    logic         deal_short;
    logic         ret_err;

    int n_checks = 0;
    int n_pass = 0;
    logic [105:0] model_avail;
    int model_cnt;

    deck_dealer dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .deal_req(deal_req), .deal_num(deal_num),
        .draw_ready(draw_ready), .draw_done(draw_done), .drawn_idx(drawn_idx),
        .ret_valid(ret_valid), .ret_idx(ret_idx),
        .draw_one(draw_one), .available_card(available_card), .remain_cnt(remain_cnt),
        .card_valid(card_valid), .card_idx(card_idx), .busy(busy),
        .deal_done(deal_done), .deal_short(deal_short), .ret_err(ret_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input bit use_peer);
        @(negedge clk);
        if (use_peer) interboard_rst = 1'b1; else rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        interboard_rst = 1'b0;
        model_avail = '1;
        model_cnt = 106;
    endtask

    task automatic start_deal(input logic [3:0] num);
        deal_req = 1'b1;
        deal_num = num;
        @(negedge clk);
        deal_req = 1'b0;
    endtask

    // Waits for draw_one, answers with idx one cycle later, checks the dealt card
    task automatic engine_draw(input logic [6:0] idx, input bit expect_card);
        int n = 0;
        while (!draw_one && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (draw_one !== 1'b1) $display("FAIL draw_one_wait: got %b required 1", draw_one);
        else n_pass++;
        draw_done = 1'b1;
        drawn_idx = idx;
        @(negedge clk);
        draw_done = 1'b0;
        n_checks++;
        if (card_valid !== expect_card || (expect_card && card_idx !== idx))
            $display("FAIL card_out: got valid=%b idx=%0d required valid=%b idx=%0d",
                     card_valid, card_idx, expect_card, idx);
        else n_pass++;
    endtask

    task automatic wait_done(input bit short_exp);
        int n = 0;
        while (!deal_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (deal_done !== 1'b1 || deal_short !== short_exp)
            $display("FAIL deal_done: got done=%b short=%b required done=1 short=%b",
                     deal_done, deal_short, short_exp);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (deal_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL deal_end_idle: got done=%b busy=%b required 0 0", deal_done, busy);
        else n_pass++;
    endtask

    // Deals ncards drawn lowest-available-first, then expects the end of the deal
    task automatic deal_n(input logic [3:0] num, input int ncards, input bit short_exp);
        int idx;
        start_deal(num);
        for (int c = 0; c < ncards; c++) begin
            idx = -1;
            for (int i = 105; i >= 0; i--) if (model_avail[i]) idx = i;
            engine_draw(7'(idx), 1'b1);
            model_avail[idx] = 1'b0;
            model_cnt--;
            if (c != ncards - 1) begin
                n_checks++;
                if (deal_done !== 1'b0) $display("FAIL early_done: got 1 required 0 at card %0d", c);
                else n_pass++;
            end
        end
        wait_done(short_exp);
        n_checks++;
        if (available_card !== model_avail || remain_cnt !== 7'(model_cnt))
            $display("FAIL mask_count: got remain=%0d required %0d (mask %s)", remain_cnt,
                     model_cnt, (available_card === model_avail) ? "equal" : "differs");
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_checks++;
        if (available_card !== {106{1'b1}} || remain_cnt !== 7'd106 || card_idx !== 7'd0)
            $display("FAIL reset_state: got remain=%0d card_idx=%0d required 106 0", remain_cnt, card_idx);
        else n_pass++;
        n_checks++;
        if ({draw_one, card_valid, busy, deal_done, deal_short, ret_err} !== 6'b0)
            $display("FAIL reset_pulses: got %b required 000000",
                     {draw_one, card_valid, busy, deal_done, deal_short, ret_err});
        else n_pass++;
    endtask

    task automatic test_empty_deal();
        start_deal(4'd0);
        n_checks++;
        if (deal_done !== 1'b1 || busy !== 1'b1 || draw_one !== 1'b0)
            $display("FAIL empty_deal: got done=%b busy=%b draw=%b required 1 1 0", deal_done, busy, draw_one);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || remain_cnt !== 7'd106)
            $display("FAIL empty_deal_end: got busy=%b remain=%0d required 0 106", busy, remain_cnt);
        else n_pass++;
    endtask

    task automatic test_three_cards();
        start_deal(4'd3);
        engine_draw(7'd5, 1'b1);
        engine_draw(7'd17, 1'b1);
        engine_draw(7'd40, 1'b1);
        wait_done(1'b0);
        model_avail[5] = 1'b0;
        model_avail[17] = 1'b0;
        model_avail[40] = 1'b0;
        model_cnt = 103;
        n_checks++;
        if (available_card[5] !== 1'b0 || available_card[17] !== 1'b0 ||
            available_card[40] !== 1'b0 || remain_cnt !== 7'd103)
            $display("FAIL three_cards: got remain=%0d bits=%b%b%b required 103 000", remain_cnt,
                     available_card[5], available_card[17], available_card[40]);
        else n_pass++;
    endtask

    task automatic do_return(input logic [6:0] idx);
        ret_valid = 1'b1;
        ret_idx = idx;
        @(negedge clk);
        ret_valid = 1'b0;
    endtask

    task automatic test_returns();
`ifdef DECK_RET_EN
        do_return(7'd17);
        model_avail[17] = 1'b1;
        model_cnt = 104;
        n_checks++;
        if (available_card[17] !== 1'b1 || remain_cnt !== 7'd104 || ret_err !== 1'b0)
            $display("FAIL return_ok: got bit=%b remain=%0d err=%b required 1 104 0",
                     available_card[17], remain_cnt, ret_err);
        else n_pass++;
        do_return(7'd17);
        n_checks++;
        if (ret_err !== 1'b1 || remain_cnt !== 7'd104)
            $display("FAIL return_dup: got err=%b remain=%0d required 1 104", ret_err, remain_cnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ret_err !== 1'b0) $display("FAIL ret_err_pulse: got 1 required 0");
        else n_pass++;
        do_return(7'd110);
        n_checks++;
        if (ret_err !== 1'b1 || remain_cnt !== 7'd104)
            $display("FAIL return_range: got err=%b remain=%0d required 1 104", ret_err, remain_cnt);
        else n_pass++;
        @(negedge clk);
`else
        do_return(7'd17);
        n_checks++;
        if (available_card[17] !== 1'b0 || remain_cnt !== 7'd103 || ret_err !== 1'b0)
            $display("FAIL return_ignored: got bit=%b remain=%0d err=%b required 0 103 0",
                     available_card[17], remain_cnt, ret_err);
        else n_pass++;
`endif
    endtask

    task automatic test_drain_short();
        while (model_cnt > 2) begin
            if (model_cnt - 2 >= 14) deal_n(4'd14, 14, 1'b0);
            else deal_n(4'(model_cnt - 2), model_cnt - 2, 1'b0);
        end
        n_checks++;
        if (remain_cnt !== 7'd2) $display("FAIL drained: got %0d required 2", remain_cnt);
        else n_pass++;
        deal_n(4'd4, 2, 1'b1);
        n_checks++;
        if (remain_cnt !== 7'd0 || available_card !== {106{1'b0}})
            $display("FAIL empty_deck: got remain=%0d required 0", remain_cnt);
        else n_pass++;
    endtask

    task automatic test_failed_draws();
        do_reset(1'b1);
        n_checks++;
        if (remain_cnt !== 7'd106 || available_card !== {106{1'b1}})
            $display("FAIL peer_reset: got remain=%0d required 106", remain_cnt);
        else n_pass++;
        start_deal(4'd2);
        engine_draw(7'd110, 1'b0);
        engine_draw(7'd9, 1'b1);
        n_checks++;
        if (deal_done !== 1'b0) $display("FAIL retry_left: got done=1 required 0");
        else n_pass++;
        engine_draw(7'd9, 1'b0);
        engine_draw(7'd20, 1'b1);
        wait_done(1'b0);
        n_checks++;
        if (remain_cnt !== 7'd104 || available_card[9] !== 1'b0 || available_card[20] !== 1'b0)
            $display("FAIL retry_mask: got remain=%0d required 104", remain_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_deal();
        int seen = 0;
        do_reset(1'b0);
        start_deal(4'd14);
        engine_draw(7'd0, 1'b1);
        engine_draw(7'd1, 1'b1);
        for (int n = 0; n < 20 && !draw_one; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || remain_cnt !== 7'd106 || available_card !== {106{1'b1}} || card_idx !== 7'd0)
            $display("FAIL mid_reset: got busy=%b remain=%0d card_idx=%0d required 0 106 0",
                     busy, remain_cnt, card_idx);
        else n_pass++;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (deal_done || card_valid || draw_one) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL after_reset_quiet: got %0d pulses required 0", seen);
        else n_pass++;
        model_avail = '1;
        model_cnt = 106;
        deal_n(4'd15, 14, 1'b0);
        n_checks++;
        if (remain_cnt !== 7'd92) $display("FAIL clamp_14: got remain=%0d required 92", remain_cnt);
        else n_pass++;
    endtask

    initial begin
        model_avail = '1;
        model_cnt = 106;
        test_reset();
        test_empty_deal();
        test_three_cards();
        test_returns();
        test_drain_short();
        test_failed_draws();
        test_reset_mid_deal();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
